// File: rtl/intr_sequencer.sv
// intr_sequencer
// Interrupt entry/exit sequencer for the 8-bit pipelined processor.
// Entry: synchronise the pin, freeze the front end at a safe point, push the
// return PC and CCR flags through the shared DMEM port, then load the ISR
// vector from IMEM. Exit (RTI): pop flags, then PC, in reverse push order.
module intr_sequencer #(
    parameter logic [7:0] VEC_ADDR    = 8'h01,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       intr_in,
    input  logic       safe_point,
    input  logic       rti_req,
    input  logic [7:0] pc_in,
    input  logic [3:0] flags_in,
    input  logic [7:0] sp_in,
    input  logic       mem_gnt,
    input  logic [7:0] mem_rdata,
    input  logic [7:0] imem_rdata,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       sp_dec,
    output logic       sp_inc,
    output logic [7:0] imem_addr,
    output logic       stall_fetch,
    output logic       flush,
    output logic       pc_load,
    output logic [7:0] pc_load_val,
    output logic       flags_load,
    output logic [3:0] flags_load_val,
    output logic       in_isr
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FREEZE  = 3'd1,
        PUSH_PC = 3'd2,
        PUSH_F  = 3'd3,
        VEC     = 3'd4,
        POP_F   = 3'd5,
        POP_PC  = 3'd6
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic                   pin_rise;
    logic                   pending_q;
    logic [7:0]             saved_pc_q;
    logic [3:0]             saved_flags_q;
    logic                   in_isr_q;
    logic                   capture;
    logic                   set_isr;
    logic                   clr_isr;

    // Pops read the slot just above the current stack pointer (8-bit wrap).
    function automatic logic [7:0] pop_addr(input logic [7:0] sp);
        return sp + 8'd1;
    endfunction

    // Metastability chain on the raw pin plus one flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], intr_in};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // A held-high pin produces exactly one rise.
    assign pin_rise = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

    // Single-entry pending latch; clearing on capture wins, extra edges are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
        end else if (capture) begin
            pending_q <= 1'b0;
        end else if (pin_rise) begin
            pending_q <= 1'b1;
        end
    end

    // Return context is sampled once, at the cycle the pipeline reports drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saved_pc_q    <= 8'h00;
            saved_flags_q <= 4'h0;
        end else if (capture) begin
            saved_pc_q    <= pc_in;
            saved_flags_q <= flags_in;
        end
    end

    // ISR-active flag: raised with the vector load, dropped with the PC restore.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_isr_q <= 1'b0;
        end else if (set_isr) begin
            in_isr_q <= 1'b1;
        end else if (clr_isr) begin
            in_isr_q <= 1'b0;
        end
    end

    assign in_isr = in_isr_q;

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; memory requests hold steady until granted.
    always_comb begin
        state_d        = state_q;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = 8'h00;
        mem_wdata      = 8'h00;
        sp_dec         = 1'b0;
        sp_inc         = 1'b0;
        imem_addr      = 8'h00;
        stall_fetch    = 1'b0;
        flush          = 1'b0;
        pc_load        = 1'b0;
        pc_load_val    = 8'h00;
        flags_load     = 1'b0;
        flags_load_val = 4'h0;
        capture        = 1'b0;
        set_isr        = 1'b0;
        clr_isr        = 1'b0;

        case (state_q)
            IDLE: begin
                // No nesting: a pending request waits until the ISR has exited.
                if (pending_q && !in_isr_q) begin
                    state_d = FREEZE;
                end else if (rti_req && in_isr_q) begin
                    state_d = POP_F;
                end
            end

            FREEZE: begin
                stall_fetch = 1'b1;
                flush       = 1'b1;
                if (safe_point) begin
                    capture = 1'b1;
                    state_d = PUSH_PC;
                end
            end

            PUSH_PC: begin
                stall_fetch = 1'b1;
                mem_req     = 1'b1;
                mem_we      = 1'b1;
                mem_addr    = sp_in;
                mem_wdata   = saved_pc_q;
                if (mem_gnt) begin
                    sp_dec  = 1'b1;
                    state_d = PUSH_F;
                end
            end

            PUSH_F: begin
                stall_fetch = 1'b1;
                mem_req     = 1'b1;
                mem_we      = 1'b1;
                mem_addr    = sp_in;
                mem_wdata   = {4'b0000, saved_flags_q};
                if (mem_gnt) begin
                    sp_dec  = 1'b1;
                    state_d = VEC;
                end
            end

            VEC: begin
                stall_fetch = 1'b1;
                imem_addr   = VEC_ADDR;
                pc_load     = 1'b1;
                pc_load_val = imem_rdata;
                set_isr     = 1'b1;
                state_d     = IDLE;
            end

            POP_F: begin
                stall_fetch = 1'b1;
                flush       = 1'b1;
                mem_req     = 1'b1;
                mem_addr    = pop_addr(sp_in);
                if (mem_gnt) begin
                    flags_load     = 1'b1;
                    flags_load_val = mem_rdata[3:0];
                    sp_inc         = 1'b1;
                    state_d        = POP_PC;
                end
            end

            POP_PC: begin
                stall_fetch = 1'b1;
                flush       = 1'b1;
                mem_req     = 1'b1;
                mem_addr    = pop_addr(sp_in);
                if (mem_gnt) begin
                    pc_load     = 1'b1;
                    pc_load_val = mem_rdata;
                    sp_inc      = 1'b1;
                    clr_isr     = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_intr_sequencer.sv
// Directed testbench for intr_sequencer: DMEM/SP/IMEM environment model plus
// a linear sequence of entry, drain-wait, back-pressure, RTI, re-entry and
// mid-sequence reset scenarios.
module tb_intr_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       intr_in;
    logic       safe_point;
    logic       rti_req;
    logic [7:0] pc_in;
    logic [3:0] flags_in;
    logic [7:0] sp_in;
    logic       mem_gnt;
    logic [7:0] mem_rdata;
    logic [7:0] imem_rdata;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       sp_dec;
    logic       sp_inc;
    logic [7:0] imem_addr;
    logic       stall_fetch;
    logic       flush;
    logic       pc_load;
    logic [7:0] pc_load_val;
    logic       flags_load;
    logic [3:0] flags_load_val;
    logic       in_isr;

    logic [7:0]  tb_mem [0:255];
    logic [7:0]  sp_model = 8'hFF;
    int          n_dec = 0;
    int          n_inc = 0;
    int          n_both = 0;
    int          cyc_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [44:0] all_outs;

    intr_sequencer #(.VEC_ADDR(8'h01), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .intr_in        (intr_in),
        .safe_point     (safe_point),
        .rti_req        (rti_req),
        .pc_in          (pc_in),
        .flags_in       (flags_in),
        .sp_in          (sp_in),
        .mem_gnt        (mem_gnt),
        .mem_rdata      (mem_rdata),
        .imem_rdata     (imem_rdata),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .sp_dec         (sp_dec),
        .sp_inc         (sp_inc),
        .imem_addr      (imem_addr),
        .stall_fetch    (stall_fetch),
        .flush          (flush),
        .pc_load        (pc_load),
        .pc_load_val    (pc_load_val),
        .flags_load     (flags_load),
        .flags_load_val (flags_load_val),
        .in_isr         (in_isr)
    );

    always #5 clk = ~clk;

    assign all_outs = {mem_req, mem_we, mem_addr, mem_wdata, sp_dec, sp_inc, imem_addr,
                       stall_fetch, flush, pc_load, pc_load_val, flags_load,
                       flags_load_val, in_isr};

    // Environment: data memory, stack pointer register, IMEM holding the vector.
    assign sp_in      = sp_model;
    assign mem_rdata  = tb_mem[mem_addr];
    assign imem_rdata = (imem_addr == 8'h01) ? 8'hE0 : 8'h00;

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (mem_req && mem_gnt && mem_we) tb_mem[mem_addr] <= mem_wdata;
        if (sp_dec) begin
            sp_model <= sp_model - 8'd1;
            n_dec    <= n_dec + 1;
        end
        if (sp_inc) begin
            sp_model <= sp_model + 8'd1;
            n_inc    <= n_inc + 1;
        end
        if (sp_dec && sp_inc) n_both <= n_both + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse the pin for one cycle and follow it into FREEZE (3 edges to pending, 1 more to FREEZE).
    task automatic trigger_to_freeze();
        intr_in = 1'b1;
        tick();
        intr_in = 1'b0;
        tick();
        tick();
        chk("pre_freeze_stall", stall_fetch, 0);
        tick();
        chk("freeze_stall", stall_fetch, 1);
        chk("freeze_flush", flush, 1);
        chk("freeze_no_req", mem_req, 0);
    endtask

    // From a FREEZE cycle with safe_point=1 and mem_gnt=1: PUSH_PC, PUSH_F, VEC, IDLE.
    task automatic entry(input logic [7:0] epc, input logic [3:0] ef, input logic [7:0] sp0);
        logic [7:0] sm1;
        sm1 = sp0 - 8'd1;
        tick();
        pc_in    = 8'hAA;
        flags_in = 4'hF;
        chk("push_pc_req", mem_req, 1);
        chk("push_pc_we", mem_we, 1);
        chk("push_pc_addr", mem_addr, sp0);
        chk("push_pc_data", mem_wdata, epc);
        chk("push_pc_dec", sp_dec, 1);
        chk("push_pc_flush", flush, 0);
        chk("push_pc_stall", stall_fetch, 1);
        tick();
        chk("push_f_addr", mem_addr, sm1);
        chk("push_f_data", mem_wdata, {4'h0, ef});
        chk("push_f_dec", sp_dec, 1);
        tick();
        chk("vec_pc_load", pc_load, 1);
        chk("vec_pc_val", pc_load_val, 8'hE0);
        chk("vec_imem_addr", imem_addr, 8'h01);
        chk("vec_stall", stall_fetch, 1);
        chk("vec_no_req", mem_req, 0);
        chk("vec_in_isr", in_isr, 0);
        tick();
        chk("entry_done_pc_load", pc_load, 0);
        chk("entry_done_stall", stall_fetch, 0);
        chk("entry_done_in_isr", in_isr, 1);
        chk("mem_pushed_pc", tb_mem[sp0], epc);
        chk("mem_pushed_flags", tb_mem[sm1], {4'h0, ef});
    endtask

    // RTI from IDLE inside the ISR, mem_gnt=1: POP_F, POP_PC, IDLE.
    task automatic do_rti(input logic [3:0] ef, input logic [7:0] epc, input logic [7:0] sp0);
        logic [7:0] a1;
        logic [7:0] a2;
        a1 = sp0 + 8'd1;
        a2 = sp0 + 8'd2;
        rti_req = 1'b1;
        tick();
        rti_req = 1'b0;
        chk("pop_f_stall", stall_fetch, 1);
        chk("pop_f_flush", flush, 1);
        chk("pop_f_req", mem_req, 1);
        chk("pop_f_we", mem_we, 0);
        chk("pop_f_addr", mem_addr, a1);
        chk("pop_f_flags_load", flags_load, 1);
        chk("pop_f_flags_val", flags_load_val, ef);
        chk("pop_f_inc", sp_inc, 1);
        chk("pop_f_pc_load", pc_load, 0);
        tick();
        chk("pop_pc_addr", mem_addr, a2);
        chk("pop_pc_load", pc_load, 1);
        chk("pop_pc_val", pc_load_val, epc);
        chk("pop_pc_inc", sp_inc, 1);
        chk("pop_pc_flags_load", flags_load, 0);
        chk("pop_pc_stall", stall_fetch, 1);
        tick();
        chk("rti_done_stall", stall_fetch, 0);
        chk("rti_done_in_isr", in_isr, 0);
        chk("rti_done_req", mem_req, 0);
    endtask

    initial begin
        int         base;
        logic [7:0] sp_chk;
        rst_n      = 1'b0;
        intr_in    = 1'b0;
        safe_point = 1'b1;
        rti_req    = 1'b0;
        pc_in      = 8'h25;
        flags_in   = 4'b0101;
        mem_gnt    = 1'b1;

        // Reset state
        #1;
        chk("reset_outputs", all_outs, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_outputs", all_outs, 0);

        // Basic entry
        base = n_dec;
        trigger_to_freeze();
        entry(8'h25, 4'h5, 8'hFF);
        chk("entry_dec_pulses", n_dec - base, 2);
        sp_chk = sp_model;
        chk("entry_sp", sp_chk, 8'hFD);

        // RTI restores flags then PC
        base = n_inc;
        do_rti(4'h5, 8'h25, 8'hFD);
        chk("rti_inc_pulses", n_inc - base, 2);
        sp_chk = sp_model;
        chk("rti_sp", sp_chk, 8'hFF);

        // Drain wait: five cycles with safe_point low, capture on the rising cycle
        safe_point = 1'b0;
        pc_in      = 8'h40;
        flags_in   = 4'h0;
        trigger_to_freeze();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_no_req", mem_req, 0);
            chk("drain_stall", stall_fetch, 1);
        end
        safe_point = 1'b1;
        pc_in      = 8'h41;
        flags_in   = 4'hA;
        entry(8'h41, 4'hA, 8'hFF);
        do_rti(4'hA, 8'h41, 8'hFD);

        // Arbiter back-pressure: grant withheld three cycles in PUSH_PC
        pc_in    = 8'h33;
        flags_in = 4'h3;
        mem_gnt  = 1'b0;
        trigger_to_freeze();
        base = cyc_cnt;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_req", mem_req, 1);
            chk("bp_addr", mem_addr, 8'hFF);
            chk("bp_data", mem_wdata, 8'h33);
            chk("bp_no_dec", sp_dec, 0);
        end
        tick();
        mem_gnt = 1'b1;
        #1;
        chk("bp_gnt_addr", mem_addr, 8'hFF);
        chk("bp_gnt_data", mem_wdata, 8'h33);
        chk("bp_gnt_dec", sp_dec, 1);
        tick();
        chk("bp_push_f_data", mem_wdata, 8'h03);
        chk("bp_push_f_dec", sp_dec, 1);
        tick();
        chk("bp_vec_pc_load", pc_load, 1);
        chk("bp_entry_cycles", cyc_cnt - base + 1, 7);
        tick();
        chk("bp_in_isr", in_isr, 1);
        chk("bp_stall_low", stall_fetch, 0);
        do_rti(4'h3, 8'h33, 8'hFD);

        // Second edge during the ISR, then a held-high pin
        pc_in    = 8'h50;
        flags_in = 4'h6;
        trigger_to_freeze();
        entry(8'h50, 4'h6, 8'hFF);
        intr_in = 1'b1;
        tick();
        intr_in = 1'b0;
        tick();
        tick();
        intr_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("isr_no_nest", stall_fetch, 0);
        end
        do_rti(4'h6, 8'h50, 8'hFD);
        tick();
        chk("reentry_freeze_stall", stall_fetch, 1);
        chk("reentry_freeze_flush", flush, 1);
        pc_in    = 8'h60;
        flags_in = 4'h9;
        entry(8'h60, 4'h9, 8'hFF);
        for (int i = 0; i < 4; i++) tick();
        do_rti(4'h9, 8'h60, 8'hFD);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("held_pin_single_entry", stall_fetch, 0);
        end
        intr_in = 1'b0;

        // rti_req outside the ISR is ignored
        rti_req = 1'b1;
        tick();
        rti_req = 1'b0;
        chk("stray_rti_outputs", all_outs, 0);
        tick();
        chk("stray_rti_outputs_next", all_outs, 0);

        // Reset during PUSH_F with a further request pending
        pc_in    = 8'h70;
        flags_in = 4'h1;
        trigger_to_freeze();
        intr_in = 1'b1;
        tick();
        tick();
        mem_gnt = 1'b0;
        intr_in = 1'b0;
        #1;
        chk("rst_seq_push_f_req", mem_req, 1);
        chk("rst_seq_push_f_data", mem_wdata, 8'h01);
        chk("rst_seq_push_f_dec", sp_dec, 0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs, 0);
        tick();
        tick();
        rst_n   = 1'b1;
        mem_gnt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("after_reset_idle", all_outs, 0);
        end
        chk("pushed_pc_kept", tb_mem[8'hFF], 8'h70);
        chk("sp_pulse_overlap", n_both, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
